// File: rtl/alarm_pkg.sv
// Shared alarm-clock constants: clock moduli, alarm defaults, FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package alarm_pkg;

    // Clock moduli shared with the minute/hour counter chain.
    localparam int MIN_N = 60;
    localparam int HR_N  = 24;
    localparam int MW    = $clog2(MIN_N);
    localparam int HW    = $clog2(HR_N);

    // Defaults for the alarm controller behaviour.
    localparam int DEF_SNOOZE_MIN = 5;
    localparam int DEF_RING_MIN   = 10;
    localparam int DEF_MAX_SNOOZE = 3;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } alarm_state_t;

    // Width of a counter that must hold 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_if.sv
// Bundle of time, control and status signals between clock logic and the alarm controller.
// Latency: n/a (wiring only).
// Backpressure: none; all controls are pulses or levels.
interface alarm_if;
    import alarm_pkg::*;

    logic [MW-1:0] cur_min;       // running minute
    logic [HW-1:0] cur_hr;        // running hour
    logic          min_tick;      // one pulse per elapsed minute
    logic          arm;           // alarm enable level
    logic          alarm_load;    // capture load_min/load_hr
    logic [MW-1:0] load_min;
    logic [HW-1:0] load_hr;
    logic          snooze;        // snooze request pulse
    logic          stop;          // stop request pulse
    logic [MW-1:0] alarm_min;     // stored alarm minute
    logic [HW-1:0] alarm_hr;      // stored alarm hour
    logic [1:0]    state;         // 0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZED
    logic          buzzer;
    logic [1:0]    snoozes_left;

    modport master (
        output cur_min, cur_hr, min_tick, arm, alarm_load, load_min, load_hr, snooze, stop,
        input  alarm_min, alarm_hr, state, buzzer, snoozes_left
    );

    modport slave (
        input  cur_min, cur_hr, min_tick, arm, alarm_load, load_min, load_hr, snooze, stop,
        output alarm_min, alarm_hr, state, buzzer, snoozes_left
    );

endinterface

// File: rtl/alarm_match_det.sv
// Stores the alarm time (range-checked loads) and detects the rising edge of time==alarm.
// Latency: alarm registers update one edge after a valid load; match/trigger are combinational.
// Backpressure: none; out-of-range loads are dropped.
// Ports: clk, rst (async active-low), cur_min/cur_hr, alarm_load/load_min/load_hr in;
//        alarm_min/alarm_hr (registered), load_ok, match, trigger out.
module alarm_match_det
    import alarm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [MW-1:0] cur_min,
    input  logic [HW-1:0] cur_hr,
    input  logic          alarm_load,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hr,
    output logic [MW-1:0] alarm_min,
    output logic [HW-1:0] alarm_hr,
    output logic          load_ok,
    output logic          match,
    output logic          trigger
);

    logic match_q;

    assign load_ok = (int'(load_min) < MIN_N) && (int'(load_hr) < HR_N);
    assign match   = (cur_min == alarm_min) && (cur_hr == alarm_hr);
    // Only a fresh coincidence rings; holding the matching time does not re-fire.
    assign trigger = match & ~match_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_min <= '0;
            alarm_hr  <= '0;
            match_q   <= 1'b0;
        end else begin
            match_q <= match;
            if (alarm_load && load_ok) begin
                alarm_min <= load_min;
                alarm_hr  <= load_hr;
            end
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze/timeout FSM driving the buzzer from the running time and a stored alarm.
// Latency: state and buzzer change one edge after the causing input; buzzer is register-decoded.
// Backpressure: none; lower-priority requests in the same cycle are dropped.
// Ports: clk, rst (async active-low), bus (alarm_if.slave: time, controls in; alarm, status out).
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = DEF_SNOOZE_MIN,
    parameter int RING_MIN   = DEF_RING_MIN,
    parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
    input  logic    clk,
    input  logic    rst,
    alarm_if.slave  bus
);

    localparam int RW = cnt_w(RING_MIN);
    localparam int SW = cnt_w(SNOOZE_MIN);
    localparam int LW = cnt_w(MAX_SNOOZE);

    alarm_state_t  state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;     // ticks rung so far in this ring burst
    logic [SW-1:0] snz_q, snz_d;       // ticks remaining in snooze
    logic [LW-1:0] left_q, left_d;     // snoozes remaining this event
    logic          load_ok, match, trigger;

    alarm_match_det u_match (
        .clk        (clk),
        .rst        (rst),
        .cur_min    (bus.cur_min),
        .cur_hr     (bus.cur_hr),
        .alarm_load (bus.alarm_load),
        .load_min   (bus.load_min),
        .load_hr    (bus.load_hr),
        .alarm_min  (bus.alarm_min),
        .alarm_hr   (bus.alarm_hr),
        .load_ok    (load_ok),
        .match      (match),
        .trigger    (trigger)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DISARMED;
            ring_q  <= '0;
            snz_q   <= '0;
            left_q  <= LW'(MAX_SNOOZE);
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            left_q  <= left_d;
        end
    end

    // Priority: disarm, load, stop, snooze, tick/trigger. Ticks are only counted
    // while already in RINGING/SNOOZED, so a tick in the entry cycle is ignored.
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        left_d  = left_q;
        if (!bus.arm) begin
            state_d = DISARMED;
            ring_d  = '0;
            snz_d   = '0;
            left_d  = LW'(MAX_SNOOZE);
        end else if (bus.alarm_load) begin
            // A valid load cancels any event in progress; a bad load is a no-op.
            if (load_ok) begin
                state_d = ARMED;
                ring_d  = '0;
                snz_d   = '0;
            end
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_d = RINGING;
                        ring_d  = '0;
                        left_d  = LW'(MAX_SNOOZE);
                    end
                end
                RINGING: begin
                    if (bus.stop || (bus.snooze && left_q == '0)) begin
                        state_d = ARMED;
                        ring_d  = '0;
                    end else if (bus.snooze) begin
                        state_d = SNOOZED;
                        snz_d   = SW'(SNOOZE_MIN);
                        left_d  = left_q - 1'b1;
                    end else if (bus.min_tick) begin
                        if (int'(ring_q) >= RING_MIN - 1) begin
                            state_d = ARMED;
                            ring_d  = '0;
                        end else begin
                            ring_d = ring_q + 1'b1;
                        end
                    end
                end
                SNOOZED: begin
                    if (bus.stop) begin
                        state_d = ARMED;
                        snz_d   = '0;
                    end else if (bus.min_tick) begin
                        // <=1 rather than ==1 so a zero count can never wrap.
                        if (snz_q <= SW'(1)) begin
                            state_d = RINGING;
                            ring_d  = '0;
                            snz_d   = '0;
                        end else begin
                            snz_d = snz_q - 1'b1;
                        end
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.buzzer       = (state_q == RINGING);
    assign bus.snoozes_left = 2'(left_q);

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: driver pushes reference-model expectations,
// monitor compares DUT outputs after every clock edge.
// Directed scenarios first, then randomized stimulus.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int S_DIS = 0, S_ARM = 1, S_RING = 2, S_SNZ = 3;

    typedef struct {
        int st;
        int amin;
        int ahr;
        int left;
        int buz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    alarm_if bus ();

    alarm_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    // Reference model: alarm held as minute-of-day, ringing/snoozing tracked as ticks remaining.
    int m_st, m_amin, m_ahr, m_left, m_ring_rem, m_snz_rem;
    bit m_was_hit;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = S_DIS; m_amin = 0; m_ahr = 0; m_left = DEF_MAX_SNOOZE;
        m_ring_rem = 0; m_snz_rem = 0; m_was_hit = 1'b0;
    endfunction

    // Evaluate one clock edge with the inputs currently on the bus.
    function automatic void model_step();
        int now_mod, alarm_mod;
        bit hit, rise, ok;
        exp_t e;
        if (!rst) begin
            model_reset();
        end else begin
            now_mod   = int'(bus.cur_hr) * MIN_N + int'(bus.cur_min);
            alarm_mod = m_ahr * MIN_N + m_amin;
            hit  = (now_mod == alarm_mod);
            rise = hit && !m_was_hit;
            ok   = (int'(bus.load_min) < MIN_N) && (int'(bus.load_hr) < HR_N);
            m_was_hit = hit;
            if (!bus.arm) begin
                m_st = S_DIS; m_left = DEF_MAX_SNOOZE;
            end else if (bus.alarm_load) begin
                if (ok) m_st = S_ARM;
            end else if (m_st == S_DIS) begin
                m_st = S_ARM;
            end else if (m_st == S_ARM) begin
                if (rise) begin
                    m_st = S_RING; m_ring_rem = DEF_RING_MIN; m_left = DEF_MAX_SNOOZE;
                end
            end else if (m_st == S_RING) begin
                if (bus.stop) m_st = S_ARM;
                else if (bus.snooze) begin
                    if (m_left == 0) m_st = S_ARM;
                    else begin
                        m_st = S_SNZ; m_snz_rem = DEF_SNOOZE_MIN; m_left--;
                    end
                end else if (bus.min_tick) begin
                    m_ring_rem--;
                    if (m_ring_rem == 0) m_st = S_ARM;
                end
            end else begin
                if (bus.stop) m_st = S_ARM;
                else if (bus.min_tick) begin
                    m_snz_rem--;
                    if (m_snz_rem == 0) begin
                        m_st = S_RING; m_ring_rem = DEF_RING_MIN;
                    end
                end
            end
            if (bus.alarm_load && ok) begin
                m_amin = int'(bus.load_min);
                m_ahr  = int'(bus.load_hr);
            end
        end
        e.st = m_st; e.amin = m_amin; e.ahr = m_ahr; e.left = m_left;
        e.buz = (m_st == S_RING) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    // Called at a negedge: record expectation for the coming posedge, advance to the next negedge.
    task automatic cyc();
        model_step();
        @(negedge clk);
        bus.min_tick   = 1'b0;
        bus.alarm_load = 1'b0;
        bus.snooze     = 1'b0;
        bus.stop       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.min_tick = 1'b1;
            cyc();
        end
    endtask

    // From ARMED with alarm 07:30: step the time off and back onto the alarm.
    task automatic retrig();
        bus.cur_hr = 5'd7; bus.cur_min = 6'd31; cyc();
        bus.cur_min = 6'd30; cyc();
    endtask

    // Monitor: compare every edge for which the driver issued an expectation.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_state",  int'(bus.state),        mon_e.st);
                check("sb_amin",   int'(bus.alarm_min),    mon_e.amin);
                check("sb_ahr",    int'(bus.alarm_hr),     mon_e.ahr);
                check("sb_left",   int'(bus.snoozes_left), mon_e.left);
                check("sb_buzzer", int'(bus.buzzer),       mon_e.buz);
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.cur_min = '0; bus.cur_hr = '0; bus.min_tick = 1'b0; bus.arm = 1'b0;
        bus.alarm_load = 1'b0; bus.load_min = '0; bus.load_hr = '0;
        bus.snooze = 1'b0; bus.stop = 1'b0;
        model_reset();
        @(negedge clk);
        cyc(); cyc();
        check("rst_state", int'(bus.state), 0);
        check("rst_left",  int'(bus.snoozes_left), 3);
        check("rst_buzz",  int'(bus.buzzer), 0);

        // 1: load 07:30, approach and hit it, stop, hold time.
        rst = 1'b1; bus.arm = 1'b1; cyc();
        bus.alarm_load = 1'b1; bus.load_min = 6'd30; bus.load_hr = 5'd7;
        bus.cur_hr = 5'd7; bus.cur_min = 6'd29; cyc();
        cyc();
        bus.cur_min = 6'd30; cyc();
        check("t1_buzz_on", int'(bus.buzzer), 1);
        bus.stop = 1'b1; cyc();
        cyc(); cyc(); cyc();
        check("t1_no_retrig", int'(bus.state), 1);

        // 2: snooze, 4 ticks silent, 5th re-rings.
        retrig();
        bus.snooze = 1'b1; cyc();
        check("t2_snz_state", int'(bus.state), 3);
        check("t2_snz_left",  int'(bus.snoozes_left), 2);
        ticks(4);
        check("t2_quiet", int'(bus.buzzer), 0);
        ticks(1);
        check("t2_rering", int'(bus.buzzer), 1);

        // 3: use up snoozes; the next snooze acts as stop; fresh event restores count.
        for (int i = 0; i < 2; i++) begin
            bus.snooze = 1'b1; cyc();
            ticks(5);
        end
        check("t3_left0", int'(bus.snoozes_left), 0);
        bus.snooze = 1'b1; cyc();
        check("t3_as_stop", int'(bus.state), 1);
        retrig();
        check("t3_restore", int'(bus.snoozes_left), 3);

        // 4: timeout with a tick coincident with entry.
        bus.stop = 1'b1; cyc();
        bus.cur_min = 6'd31; cyc();
        bus.cur_min = 6'd30; bus.min_tick = 1'b1; cyc();
        ticks(9);
        check("t4_still_ring", int'(bus.state), 2);
        ticks(1);
        check("t4_timeout", int'(bus.state), 1);

        // 5: stop beats snooze; disarm from SNOOZED; out-of-range load ignored.
        retrig();
        bus.stop = 1'b1; bus.snooze = 1'b1; cyc();
        check("t5_stop_wins", int'(bus.state), 1);
        retrig();
        bus.snooze = 1'b1; cyc();
        bus.arm = 1'b0; cyc();
        check("t5_disarm", int'(bus.state), 0);
        bus.arm = 1'b1; cyc();
        bus.alarm_load = 1'b1; bus.load_min = 6'd0; bus.load_hr = 5'd24; cyc();
        check("t5_bad_hr", int'(bus.alarm_hr), 7);
        check("t5_bad_st", int'(bus.state), 1);

        // 6: async reset between edges while ringing.
        retrig();
        #3 rst = 1'b0;
        #1;
        check("t6_buzz",  int'(bus.buzzer), 0);
        check("t6_state", int'(bus.state), 0);
        check("t6_amin",  int'(bus.alarm_min), 0);
        check("t6_ahr",   int'(bus.alarm_hr), 0);
        model_reset();
        @(negedge clk);
        bus.cur_min = '0; bus.cur_hr = '0;
        cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("t6_no_ring", int'(bus.state), 1);

        // Random phase.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                bus.cur_min = 6'(m_amin); bus.cur_hr = 5'(m_ahr);
            end else if (r < 45) begin
                bus.cur_min = 6'($urandom_range(0, MIN_N - 1));
                bus.cur_hr  = 5'($urandom_range(0, HR_N - 1));
            end
            bus.arm        = ($urandom_range(0, 59) != 0);
            bus.min_tick   = ($urandom_range(0, 1) == 1);
            bus.snooze     = ($urandom_range(0, 5) == 0);
            bus.stop       = ($urandom_range(0, 24) == 0);
            bus.alarm_load = ($urandom_range(0, 29) == 0);
            bus.load_min   = 6'($urandom_range(0, 63));
            bus.load_hr    = 5'($urandom_range(0, 31));
            cyc();
        end

        @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the minutes/hours counter chain in the alarm clock.
- Compares the running time (minute and hour values plus a per-minute strobe) against a stored alarm time.
- Runs a ring/snooze/timeout state machine and drives the buzzer.
- Alarm time is loaded from the set-mode logic.

Parameters:
MIN_N, 60, minute modulus (valid minutes 0..MIN_N-1)
HR_N, 24, hour modulus (valid hours 0..HR_N-1)
SNOOZE_MIN, 5, minute ticks spent in snooze before re-ringing (>=1)
RING_MIN, 10, minute ticks of continuous ringing before auto-stop (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event
MW, $clog2(MIN_N), minute width (derived)
HW, $clog2(HR_N), hour width (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cur_min  in  MW  current minute from minute counter
cur_hr  in  HW  current hour from hour counter
min_tick  in  1  one-cycle pulse per elapsed minute
arm  in  1  alarm enable switch (level)
alarm_load  in  1  one-cycle pulse: capture load_min/load_hr
load_min  in  MW  new alarm minute
load_hr  in  HW  new alarm hour
snooze  in  1  one-cycle snooze request
stop  in  1  one-cycle stop request
alarm_min  out  MW  stored alarm minute
alarm_hr  out  HW  stored alarm hour
state  out  2  0=DISARMED 1=ARMED 2=RINGING 3=SNOOZED
buzzer  out  1  high exactly while state==RINGING
snoozes_left  out  2  remaining snoozes in current event

Behaviour:
- Reset (rst=0, async): state=DISARMED, alarm 00:00, buzzer=0, snoozes_left=MAX_SNOOZE, ring/snooze counters=0, match_q=0.
- match = (cur_min==alarm_min && cur_hr==alarm_hr), combinational.
- match_q <= match every cycle, in every state.
- trigger = match & ~match_q.
  - A time change landing on the alarm time rings at the next edge: buzzer high 1 cycle after cur_* change.
  - Loading the alarm equal to the current time also triggers.
  - Arming while already matched does not trigger.
- Priority, highest first: arm==0, then alarm_load, then stop, then snooze, then min_tick/trigger.
- arm==0: next state DISARMED from any state; counters cleared; snoozes_left=MAX_SNOOZE.
- alarm_load:
  - If load_min<MIN_N and load_hr<HR_N: registers update next edge; RINGING/SNOOZED go to ARMED (event cancelled).
  - Otherwise the load is ignored entirely and state is unchanged.
- DISARMED: arm==1 -> ARMED.
- ARMED: trigger -> RINGING; ring_cnt=0; snoozes_left=MAX_SNOOZE.
- RINGING:
  - stop -> ARMED.
  - snooze with snoozes_left>0 -> SNOOZED; snz_cnt=SNOOZE_MIN; snoozes_left-1.
  - snooze with snoozes_left==0 -> treated as stop (ARMED).
  - min_tick -> ring_cnt+1; on the tick making ring_cnt==RING_MIN -> ARMED.
  - stop and snooze in the same cycle: stop wins.
- SNOOZED:
  - stop -> ARMED.
  - snooze ignored.
  - min_tick decrements snz_cnt; a tick while snz_cnt==1 -> RINGING with ring_cnt=0.
- Entry cycle: a min_tick coincident with entering RINGING or SNOOZED is not counted.
- trigger in RINGING/SNOOZED is ignored (no restart).
- Counters are saturating, never wrap; widths sized for RING_MIN, SNOOZE_MIN and MAX_SNOOZE.
- All outputs registered or decoded from registers only; no combinational path from inputs to buzzer.

Decomposition:
- Shared package alarm_pkg:
  - state encoding constants (DISARMED/ARMED/RINGING/SNOOZED)
  - default SNOOZE_MIN, RING_MIN, MAX_SNOOZE
  - clock moduli MIN_N/HR_N, shared with the counter blocks
- One natural sub-module, alarm_match_det: holds alarm registers and the range check, and outputs match and trigger.
- FSM and counters stay in alarm_controller.

Test Plan:
1. Reset, arm=1, load 07:30; drive cur 07:29 then 07:30 -> state=RINGING, buzzer=1 one cycle after cur change; cur held at 07:30 gives no re-trigger after stop.
2. RINGING, snooze pulse -> SNOOZED, buzzer=0, snoozes_left=2; 4 min_ticks keep buzzer 0; 5th min_tick -> buzzer=1 next cycle.
3. Snooze 3 times (each followed by 5 ticks); 4th snooze while RINGING -> ARMED, buzzer=0; next trigger restores snoozes_left=3.
4. RINGING with no input: 10 min_ticks -> ARMED after the 10th; a tick in the entry cycle not counted (11 ticks needed if the first is coincident).
5. Same-cycle stop+snooze in RINGING -> ARMED. arm=0 mid-SNOOZED -> DISARMED. alarm_load 24:00 -> ignored, alarm stays 07:30, state unchanged.
6. rst low asynchronously mid-RINGING (between edges) -> buzzer=0 immediately, alarm 00:00, state=DISARMED; release with cur=00:00, arm=1 -> no ring (match_q edge rule applies after ARMED only if match rises).
